// File: rtl/cde_jtag_master_shifter_if.sv
// rtl/cde_jtag_master_shifter_if.sv - command/response bus of the JTAG master shifter
interface cde_jtag_master_shifter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_reset;
    logic                  cmd_ir;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_reset, cmd_ir, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_reset, cmd_ir, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cde_jtag_master_shifter.sv
// rtl/cde_jtag_master_shifter.sv - clock-divided JTAG master running IR/DR scans from RTI back to RTI
module cde_jtag_master_shifter #(
    parameter int DIVCNT     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    cde_jtag_master_shifter_if.slave cmd,
    output logic                     tclk,
    output logic                     tms,
    output logic                     tdi,
    output logic                     trst_n,
    input  logic                     tdo
);
    localparam int CW = 5;
    localparam int SW = LEN_WIDTH + 1;
    localparam logic [CW-1:0]        HALF_END = CW'(DIVCNT - 1);
    localparam logic [CW-1:0]        BIT_END  = CW'(2 * DIVCNT - 1);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(DATA_WIDTH);

    typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_TLR, S_SCAN} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [SW-1:0]         step, total;
    logic                  tlr_q, ir_q;
    logic [LEN_WIDTH-1:0]  len_q, len_in;
    logic [DATA_WIDTH-1:0] data_q, cap, rsp_data_q;
    logic                  rsp_valid_q;
    logic                  busy, accept, rise, fall, done;

    function automatic logic [SW-1:0] f_pre(input logic ir);
        return ir ? SW'(4) : SW'(3);
    endfunction

    function automatic logic f_in_shift(input logic ir, input logic [LEN_WIDTH-1:0] len,
                                        input logic [SW-1:0] s);
        return (s >= f_pre(ir)) && (s < f_pre(ir) + SW'(len));
    endfunction

    // Step s counts tck bits from the accept edge: preamble, shift bits, two-bit postamble.
    function automatic logic f_tms(input logic tlr, input logic ir,
                                   input logic [LEN_WIDTH-1:0] len, input logic [SW-1:0] s);
        logic [SW-1:0] pre;
        pre = f_pre(ir);
        if (tlr)
            return s < SW'(5);
        if (s < pre)
            return ir ? (s < SW'(2)) : (s == '0);
        if (s < pre + SW'(len))
            return s == pre + SW'(len) - SW'(1);
        return s == pre + SW'(len);
    endfunction

    function automatic logic f_tdi(input logic tlr, input logic ir, input logic [LEN_WIDTH-1:0] len,
                                   input logic [DATA_WIDTH-1:0] data, input logic [SW-1:0] s);
        logic [DATA_WIDTH-1:0] d;
        d = data >> (s - f_pre(ir));
        return !tlr && f_in_shift(ir, len, s) && d[0];
    endfunction

    assign len_in        = (cmd.cmd_len > MAX_LEN) ? MAX_LEN : cmd.cmd_len;
    assign busy          = (state == S_INIT) || (state == S_TLR) || (state == S_SCAN);
    assign cmd.cmd_ready = (state == S_IDLE) && !rsp_valid_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rsp_data_q;

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_RESET;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        done      = 1'b0;
        if (busy) begin
            rise = (cnt == HALF_END);
            fall = (cnt == BIT_END);
            done = fall && (step == total - SW'(1));
        end
        case (state)
            S_RESET: state_nxt = S_INIT;
            S_IDLE: begin
                if (cmd.cmd_valid && !rsp_valid_q) begin
                    accept = 1'b1;
                    if (cmd.cmd_reset)
                        state_nxt = S_TLR;
                    else if (len_in != '0)
                        state_nxt = S_SCAN;
                end
            end
            default: begin
                if (done)
                    state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tclk        <= 1'b0;
            tms         <= 1'b1;
            tdi         <= 1'b0;
            trst_n      <= 1'b0;
            cnt         <= '0;
            step        <= '0;
            total       <= SW'(1);
            tlr_q       <= 1'b0;
            ir_q        <= 1'b0;
            len_q       <= '0;
            data_q      <= '0;
            cap         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            trst_n      <= 1'b1;
            rsp_valid_q <= 1'b0;
            if (state == S_RESET) begin
                // INIT is a single tms=0 bit that starts on the first edge out of reset
                tms   <= 1'b0;
                tdi   <= 1'b0;
                cnt   <= '0;
                step  <= '0;
                total <= SW'(1);
            end else if (accept) begin
                tlr_q  <= cmd.cmd_reset;
                ir_q   <= cmd.cmd_ir;
                len_q  <= len_in;
                data_q <= cmd.cmd_data;
                cap    <= '0;
                cnt    <= '0;
                step   <= '0;
                total  <= cmd.cmd_reset ? SW'(6) : f_pre(cmd.cmd_ir) + SW'(len_in) + SW'(2);
                if (!cmd.cmd_reset && len_in == '0) begin
                    tms         <= 1'b0;
                    tdi         <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
                end else begin
                    tms <= f_tms(cmd.cmd_reset, cmd.cmd_ir, len_in, '0);
                    tdi <= f_tdi(cmd.cmd_reset, cmd.cmd_ir, len_in, cmd.cmd_data, '0);
                end
            end else if (fall) begin
                tclk <= 1'b0;
                cnt  <= '0;
                if (done) begin
                    tms <= 1'b0;
                    tdi <= 1'b0;
                    if (state != S_INIT) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= cap;
                    end
                end else begin
                    step <= step + SW'(1);
                    tms  <= f_tms(tlr_q, ir_q, len_q, step + SW'(1));
                    tdi  <= f_tdi(tlr_q, ir_q, len_q, data_q, step + SW'(1));
                end
            end else if (busy) begin
                cnt <= cnt + CW'(1);
                if (rise) begin
                    tclk <= 1'b1;
                    if (state == S_SCAN && f_in_shift(ir_q, len_q, step))
                        cap <= cap | (DATA_WIDTH'(tdo) << (step - f_pre(ir_q)));
                end
            end
        end
    end
endmodule

// File: tb/tb_cde_jtag_master_shifter.sv
// tb/tb_cde_jtag_master_shifter.sv - directed bench for the JTAG master shifter
module tb_cde_jtag_master_shifter;
    localparam int DW = 32;
    localparam int LW = 6;
    localparam logic [31:0] SEED = 32'h3C3C_1234;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tclk, tms, tdi, trst_n, tdo;
    logic tdo_const = 1'b0;
    logic loop_en = 1'b0;
    logic loop_load = 1'b0;
    logic [31:0] mreg;
    int rtot = 0;
    int loop_base = 0;
    logic tms_log [4096];
    logic tdi_log [4096];
    int tests = 0;
    int fails = 0;
    int n;
    int base;
    logic [63:0] tv, dv;

    cde_jtag_master_shifter_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    cde_jtag_master_shifter #(.DIVCNT(4), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk    (clk),
        .reset  (reset),
        .cmd    (bus),
        .tclk   (tclk),
        .tms    (tms),
        .tdi    (tdi),
        .trst_n (trst_n),
        .tdo    (tdo)
    );

    always #5 clk = ~clk;

    assign tdo = loop_en ? mreg[0] : tdo_const;

    // Records tms/tdi at every tclk rise; the loopback register shifts on DR shift rises.
    always @(posedge tclk or posedge loop_load) begin
        if (loop_load) begin
            mreg = SEED;
        end else begin
            tms_log[rtot] = tms;
            tdi_log[rtot] = tdi;
            if (loop_en && (rtot - loop_base) >= 3 && (rtot - loop_base) < 35)
                mreg = {tdi, mreg[31:1]};
            rtot = rtot + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int b, input int cnt, output logic [63:0] t, output logic [63:0] d);
        t = '0;
        d = '0;
        for (int r = 0; r < cnt && r < 64; r++) begin
            t[r] = tms_log[b + r];
            d[r] = tdi_log[b + r];
        end
    endtask

    task automatic send(input logic rst, input logic ir, input logic [LW-1:0] len, input logic [DW-1:0] data);
        bus.cmd_reset = rst;
        bus.cmd_ir    = ir;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        base      = rtot;
        loop_base = rtot;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_reset = 1'b1;
        bus.cmd_ir    = ~ir;
        bus.cmd_len   = 6'd1;
        bus.cmd_data  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 2000) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 1;
        while (!bus.cmd_ready && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_reset = 1'b0;
        bus.cmd_ir    = 1'b0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        repeat (3) tick();
        check("rst_tclk", 64'(tclk), 64'd0);
        check("rst_tms", 64'(tms), 64'd1);
        check("rst_tdi", 64'(tdi), 64'd0);
        check("rst_trst_n", 64'(trst_n), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);

        // Power-up: trst_n released, single INIT tck with tms=0, ready 9 clk after release
        reset = 1'b0;
        base = rtot;
        tick();
        check("init_trst_n", 64'(trst_n), 64'd1);
        check("init_tms", 64'(tms), 64'd0);
        wait_ready(n);
        check("init_ready_cycles", 64'(n), 64'd9);
        check("init_rises", 64'(rtot - base), 64'd1);
        check("init_tms_at_rise", 64'(tms_log[base]), 64'd0);

        // TAP reset sequence
        send(1'b1, 1'b0, 6'd0, 32'h0);
        check("tlr_ready_drop", 64'(bus.cmd_ready), 64'd0);
        wait_rsp(n);
        check("tlr_latency", 64'(n), 64'd48);
        check("tlr_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("tlr_rises", 64'(rtot - base), 64'd6);
        collect(base, 6, tv, dv);
        check("tlr_tms_seq", tv, 64'h1F);
        tick();
        check("tlr_rsp_pulse", 64'(bus.rsp_valid), 64'd0);
        check("tlr_ready_back", 64'(bus.cmd_ready), 64'd1);

        // IR scan len=4 data=D with tdo tied high
        tdo_const = 1'b1;
        send(1'b0, 1'b1, 6'd4, 32'hD);
        wait_rsp(n);
        check("ir_latency", 64'(n), 64'd80);
        check("ir_rsp_data", 64'(bus.rsp_data), 64'hF);
        check("ir_rises", 64'(rtot - base), 64'd10);
        collect(base, 10, tv, dv);
        check("ir_tms_seq", tv, 64'h183);
        check("ir_tdi_seq", dv, 64'h0D0);
        tick();
        check("ir_rsp_hold", 64'(bus.rsp_data), 64'hF);

        // Zero-length scan: immediate response, no tclk activity
        tdo_const = 1'b0;
        send(1'b0, 1'b0, 6'd0, 32'hFFFF_FFFF);
        check("len0_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("len0_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("len0_ready_gap", 64'(bus.cmd_ready), 64'd0);
        tick();
        check("len0_ready_back", 64'(bus.cmd_ready), 64'd1);
        repeat (2) tick();
        check("len0_no_tclk", 64'(rtot - base), 64'd0);

        // DR len=40 clamps to 32, TDO looped back through a 32-bit register
        loop_load = 1'b1;
        #1;
        loop_load = 1'b0;
        loop_en = 1'b1;
        send(1'b0, 1'b0, 6'd40, 32'hA5A5_A5A5);
        wait_rsp(n);
        check("dr40_latency", 64'(n), 64'd296);
        check("dr40_rsp_data", 64'(bus.rsp_data), 64'(SEED));
        check("dr40_rises", 64'(rtot - base), 64'd37);
        collect(base, 37, tv, dv);
        check("dr40_tms_seq", tv, 64'h0000_000C_0000_0001);
        check("dr40_tdi_seq", dv, 64'h0000_0005_2D2D_2D28);
        check("dr40_model_reg", 64'(mreg), 64'hA5A5_A5A5);
        loop_en = 1'b0;
        tick();

        // Reset during shift bit 10 of a DR scan drops the command
        send(1'b0, 1'b0, 6'd32, 32'h0000_0001);
        n = 0;
        while ((rtot - base) < 14 && n < 500) begin
            tick();
            n++;
        end
        check("mid_rises", 64'(rtot - base), 64'd14);
        check("mid_tclk_high", 64'(tclk), 64'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_tclk", 64'(tclk), 64'd0);
        check("mid_rst_tms", 64'(tms), 64'd1);
        check("mid_rst_trst_n", 64'(trst_n), 64'd0);
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_ready", 64'(bus.cmd_ready), 64'd0);
        tick();
        reset = 1'b0;
        base = rtot;
        tick();
        check("reinit_trst_n", 64'(trst_n), 64'd1);
        wait_ready(n);
        check("reinit_ready_cycles", 64'(n), 64'd9);
        check("reinit_rises", 64'(rtot - base), 64'd1);
        check("reinit_rsp_valid", 64'(bus.rsp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
